// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci stream generator.
package fib_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/fib_stream_gen_ce_reg.sv
// Clock-enabled register with synchronous active-low reset; holds a, b and the term counter.
module ce_reg
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/fib_stream_gen.sv
// Fibonacci term generator: loads two seeds, streams n_terms terms over valid/ready,
// and flags adder overflow (truncating the stream or wrapping depending on WRAP).
module fib_stream_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter bit WRAP  = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_n_terms,
  input  logic [WIDTH-1:0] i_seed0,
  input  logic [WIDTH-1:0] i_seed1,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow
);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_pend;
  logic             r_overflow;
  logic             r_done;

  logic [WIDTH-1:0] w_a_d;
  logic [WIDTH-1:0] w_b_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [WIDTH:0]   w_sum;
  logic             w_load;
  logic             w_advance;
  logic             w_finish;
  logic             w_last;
  logic             w_ovf_hit;
  logic             w_reg_en;
  logic             w_run;

  assign w_run = (r_state == RUN);

  // Single WIDTH+1-bit adder; the top bit is the carry-out used for overflow detection.
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  // Without wrapping, a pending overflow makes b the final representable term.
  assign w_last = (r_cnt == CNT_W'(1)) | (r_ovf_pend & ~WRAP);

  // The sum only matters if it would actually be emitted, i.e. at least three terms remain.
  assign w_ovf_hit = w_advance & w_sum[WIDTH] & (r_cnt >= CNT_W'(3));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && (i_n_terms != '0)) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_out_ready) begin
          if (w_last) begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_reg_en = w_load | w_advance;
  assign w_a_d    = w_load ? i_seed0   : r_b;
  assign w_b_d    = w_load ? i_seed1   : w_sum[WIDTH-1:0];
  assign w_cnt_d  = w_load ? i_n_terms : (r_cnt - CNT_W'(1));

  ce_reg #(.WIDTH(WIDTH)) u_reg_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_reg_en),
    .i_d     (w_a_d),
    .o_q     (r_a)
  );

  ce_reg #(.WIDTH(WIDTH)) u_reg_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_reg_en),
    .i_d     (w_b_d),
    .o_q     (r_b)
  );

  ce_reg #(.WIDTH(CNT_W)) u_reg_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_reg_en),
    .i_d     (w_cnt_d),
    .o_q     (r_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_ovf_pend <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_finish;
      if (w_load) begin
        r_ovf_pend <= 1'b0;
        r_overflow <= 1'b0;
      end else if (w_ovf_hit) begin
        r_ovf_pend <= 1'b1;
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_out_valid = w_run;
  assign o_busy      = w_run;
  assign o_out_data  = w_run ? r_a : '0;
  assign o_out_last  = w_run & w_last;
  assign o_done      = r_done;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Self-checking bench: one truncating and one wrapping instance share stimulus and are
// compared against an arithmetic Fibonacci model.
module tb_fib_stream_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic [7:0] nTerms;
  logic [7:0] seed0;
  logic [7:0] seed1;
  logic       vld  [2];
  logic [7:0] data [2];
  logic       last [2];
  logic       busy [2];
  logic       done [2];
  logic       ovf  [2];

  int vectors     = 0;
  int miscompares = 0;

  int gotData [2][$];
  int gotLast [2][$];
  int expData [2][$];
  bit expOvf  [2];
  bit lastOvf [2];
  bit doneSeen[2];
  bit ovfSeen [2];

  bit       stallPend  [2];
  logic [7:0] stallData[2];
  logic     stallLast  [2];
  bit       prevLastAcc[2];

  always #5 clk = ~clk;

  fib_stream_gen #(.WIDTH(8), .CNT_W(8), .WRAP(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_n_terms(nTerms),
    .i_seed0(seed0), .i_seed1(seed1), .i_out_ready(ready),
    .o_out_valid(vld[0]), .o_out_data(data[0]), .o_out_last(last[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_overflow(ovf[0])
  );

  fib_stream_gen #(.WIDTH(8), .CNT_W(8), .WRAP(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_n_terms(nTerms),
    .i_seed0(seed0), .i_seed1(seed1), .i_out_ready(ready),
    .o_out_valid(vld[1]), .o_out_data(data[1]), .o_out_last(last[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_overflow(ovf[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain Fibonacci arithmetic; an unrepresentable emitted term either ends
  // the stream (truncating) or is taken modulo 256 (wrapping).
  task automatic buildExpected(input int k, input int n, input int s0, input int s1, input bit wrap);
    int p2, p1, s;
    expData[k].delete();
    expOvf[k] = lastOvf[k];
    if (n == 0) return;
    expOvf[k] = 1'b0;
    expData[k].push_back(s0);
    if (n >= 2) expData[k].push_back(s1);
    p2 = s0;
    p1 = s1;
    for (int i = 2; i < n; i++) begin
      s = p2 + p1;
      if (s > 255) begin
        expOvf[k] = 1'b1;
        if (!wrap) break;
        s = s % 256;
      end
      expData[k].push_back(s);
      p2 = p1;
      p1 = s;
    end
  endtask

  // Beat collection, stall stability and done-after-last timing, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        checkOutput($sformatf("done_timing%0d", k), done[k], prevLastAcc[k]);
        if (stallPend[k]) begin
          checkOutput($sformatf("stall_hold%0d", k), {vld[k], last[k], data[k]},
                      {1'b1, stallLast[k], stallData[k]});
        end
        if (vld[k] && ready) begin
          gotData[k].push_back(int'(data[k]));
          gotLast[k].push_back(int'(last[k]));
        end
        prevLastAcc[k] = vld[k] && ready && last[k];
        stallPend[k]   = vld[k] && !ready;
        stallData[k]   = data[k];
        stallLast[k]   = last[k];
      end else begin
        prevLastAcc[k] = 1'b0;
        stallPend[k]   = 1'b0;
      end
    end
  end

  task automatic idleCycles(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where both instances are idle.
  task automatic applyStimulus(input int n, input int s0, input int s1, input bit rndReady,
                               input bit midStart);
    bit ended[2];
    int cyc;
    for (int k = 0; k < 2; k++) begin
      gotData[k].delete();
      gotLast[k].delete();
      ended[k] = 1'b0;
      buildExpected(k, n, s0, s1, k == 1);
    end
    nTerms = 8'(n);
    seed0  = 8'(s0);
    seed1  = 8'(s1);
    start  = 1'b1;
    ready  = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    while (cyc < 400) begin
      for (int k = 0; k < 2; k++) begin
        if (!ended[k] && !busy[k]) begin
          ended[k]    = 1'b1;
          doneSeen[k] = done[k];
          ovfSeen[k]  = ovf[k];
        end
      end
      if (ended[0] && ended[1]) break;
      if (midStart && cyc == 2) begin
        nTerms = 8'd3;
        seed0  = 8'd9;
        seed1  = 8'd9;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    if (!(ended[0] && ended[1])) checkOutput($sformatf("stream_timeout_n%0d", n), 32'd0, 32'd1);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("len%0d_n%0d", k, n), gotData[k].size(), expData[k].size());
      for (int i = 0; i < expData[k].size(); i++) begin
        if (i < gotData[k].size()) begin
          checkOutput($sformatf("data%0d_beat%0d", k, i), gotData[k][i], expData[k][i]);
          checkOutput($sformatf("last%0d_beat%0d", k, i), gotLast[k][i],
                      (i == expData[k].size() - 1) ? 32'd1 : 32'd0);
        end
      end
      checkOutput($sformatf("done%0d_n%0d", k, n), doneSeen[k], (n != 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("overflow%0d_n%0d", k, n), ovfSeen[k], expOvf[k]);
      lastOvf[k] = expOvf[k];
    end
  endtask

  initial begin
    bit resetSeen;
    int waitCyc;
    rst_n  = 1'b0;
    start  = 1'b0;
    ready  = 1'b0;
    nTerms = '0;
    seed0  = '0;
    seed1  = '0;
    lastOvf = '{1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_valid%0d", k), vld[k], 32'd0);
      checkOutput($sformatf("rst_data%0d", k), data[k], 32'd0);
      checkOutput($sformatf("rst_last%0d", k), last[k], 32'd0);
      checkOutput($sformatf("rst_busy%0d", k), busy[k], 32'd0);
      checkOutput($sformatf("rst_done%0d", k), done[k], 32'd0);
      checkOutput($sformatf("rst_ovf%0d", k), ovf[k], 32'd0);
    end
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] basic stream, ready held high");
    applyStimulus(10, 0, 1, 1'b0, 1'b0);
    checkOutput("t1_term10", gotData[0][9], 32'd34);
    idleCycles(2);

    $display("[TB] same stream with random backpressure");
    applyStimulus(10, 0, 1, 1'b1, 1'b0);
    idleCycles(2);

    $display("[TB] overflow: truncate vs wrap, n=20");
    applyStimulus(20, 0, 1, 1'b1, 1'b0);
    checkOutput("t3_len", gotData[0].size(), 32'd14);
    checkOutput("t3_final", gotData[0][13], 32'd233);
    idleCycles(2);

    applyStimulus(16, 0, 1, 1'b0, 1'b0);
    checkOutput("t4_term15", gotData[1][14], 32'd121);
    checkOutput("t4_term16", gotData[1][15], 32'd98);
    idleCycles(2);

    $display("[TB] start during RUN is ignored");
    applyStimulus(10, 0, 1, 1'b0, 1'b1);
    idleCycles(2);

    $display("[TB] n_terms edge cases");
    applyStimulus(0, 5, 5, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("n0_no_beats", gotData[0].size() + gotData[1].size(), 32'd0);
    applyStimulus(1, 7, 3, 1'b1, 1'b0);
    checkOutput("n1_seed", gotData[0][0], 32'd7);
    idleCycles(2);
    applyStimulus(2, 200, 200, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] back-to-back streams");
    applyStimulus(5, 0, 1, 1'b0, 1'b0);
    checkOutput("b2b_done_at_start", done[0], 32'd1);
    applyStimulus(6, 2, 3, 1'b1, 1'b0);
    idleCycles(2);

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 2; k++) begin
      gotData[k].delete();
      gotLast[k].delete();
    end
    nTerms = 8'd10;
    seed0  = 8'd0;
    seed1  = 8'd1;
    ready  = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    resetSeen = 1'b0;
    waitCyc   = 0;
    while (!resetSeen && waitCyc < 50) begin
      @(posedge clk);
      #1;
      waitCyc++;
      if (gotData[0].size() >= 5) resetSeen = 1'b1;
    end
    if (!resetSeen) checkOutput("reset_wait_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_valid", vld[0], 32'd0);
    checkOutput("rst_mid_busy", busy[0], 32'd0);
    checkOutput("rst_mid_ovf", ovf[0], 32'd0);
    checkOutput("rst_mid_done", done[0], 32'd0);
    checkOutput("rst_mid_beats", gotData[0].size(), 32'd5);
    checkOutput("rst_mid_term5", gotData[0][4], 32'd3);
    rst_n = 1'b1;
    lastOvf = '{1'b0, 1'b0};
    idleCycles(2);
    checkOutput("rst_mid_no_done", done[0], 32'd0);
    applyStimulus(8, 1, 1, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] random streams");
    for (int r = 0; r < 8; r++) begin
      applyStimulus(int'($urandom_range(0, 24)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) idleCycles(1);
    end
    idleCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
